pc_rx_framer: RTL and testbench



---
 rtl/pc_rx_framer.sv | 203 ++++++++++++++++++++
 tb/tb_pc_rx_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_rx_framer.sv
// pc_rx_framer: RESYNC/MAGIC framing of the uart_rx byte stream, word packing and FWFT FIFO.
// Optional statistics counters are enabled by defining PC_RX_FRAMER_STATS_EN.
module pc_rx_framer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MSB_FIRST  = 1,
    parameter logic [31:0] RESYNC_SEQ = 32'h416FDC1E,
    parameter logic [31:0] MAGIC_SEQ  = 32'hD78C1B74
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [7:0]                        i_rx_byte,
    input  logic                              i_rx_byte_valid,
    input  logic                              i_read_next_word_cmd,
    output logic [8*WORD_BYTES-1:0]           o_fifo_output_word,
    output logic                              o_fifo_is_empty_sig,
    output logic                              o_fifo_is_full_sig,
    output logic [$clog2(FIFO_DEPTH):0]       o_fifo_level,
    output logic                              o_start_packet_sig,
    output logic                              o_overflow_sig,
`ifdef PC_RX_FRAMER_STATS_EN
    output logic [15:0]                       o_resync_count,
    output logic [15:0]                       o_packet_count,
    output logic [15:0]                       o_drop_count,
`endif
    output logic [1:0]                        o_state
);

    localparam int unsigned W  = 8 * WORD_BYTES;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(WORD_BYTES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          r_state;
    logic [23:0]     r_history;
    logic [CW-1:0]   r_pack_count;
    logic [W-1:0]    r_pack_word;
    logic            r_wr_pending;
    logic [W-1:0]    r_wr_word;
    logic            r_start_packet;

    logic [W-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;

    logic [31:0]     w_hist_next;
    logic            w_resync_hit;
    logic            w_magic_hit;
    logic [W-1:0]    w_pack_next;
    logic            w_byte_last;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Only the three previous bytes are stored; the incoming byte completes the 32-bit window.
    assign w_hist_next  = {r_history, i_rx_byte};
    assign w_resync_hit = i_rx_byte_valid && (w_hist_next == RESYNC_SEQ);
    assign w_magic_hit  = i_rx_byte_valid && (w_hist_next == MAGIC_SEQ);
    assign w_byte_last  = (r_pack_count == CW'(WORD_BYTES - 1));

    generate
        if (WORD_BYTES == 1) begin : g_pack_single
            assign w_pack_next = i_rx_byte;
        end else if (MSB_FIRST != 0) begin : g_pack_msb
            assign w_pack_next = {r_pack_word[W-9:0], i_rx_byte};
        end else begin : g_pack_lsb
            assign w_pack_next = {i_rx_byte, r_pack_word[W-1:8]};
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_history      <= '0;
            r_pack_count   <= '0;
            r_pack_word    <= '0;
            r_wr_pending   <= 1'b0;
            r_wr_word      <= '0;
            r_start_packet <= 1'b0;
        end else begin
            r_start_packet <= 1'b0;
            r_wr_pending   <= 1'b0;
            if (i_rx_byte_valid) begin
                r_history <= w_hist_next[23:0];
                case (r_state)
                    ST_IDLE: begin
                        if (w_resync_hit) begin
                            r_state <= ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (w_magic_hit) begin
                            r_state        <= ST_DATA;
                            r_start_packet <= 1'b1;
                            r_pack_count   <= '0;
                        end
                    end
                    ST_DATA: begin
                        // A resync drops the partial word; the matching byte itself is never packed.
                        if (w_resync_hit) begin
                            r_state      <= ST_PRE;
                            r_pack_count <= '0;
                        end else begin
                            r_pack_word <= w_pack_next;
                            if (w_byte_last) begin
                                r_pack_count <= '0;
                                r_wr_pending <= 1'b1;
                                r_wr_word    <= w_pack_next;
                            end else begin
                                r_pack_count <= r_pack_count + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_pop   = i_read_next_word_cmd && !w_empty;
    assign w_push  = r_wr_pending && (!w_full || w_pop);
    assign w_drop  = r_wr_pending && w_full && !w_pop;

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_wr_word;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef PC_RX_FRAMER_STATS_EN
    logic [15:0] r_resync_count;
    logic [15:0] r_packet_count;
    logic [15:0] r_drop_count;

    // Event counters saturate rather than wrap so a long capture never reads as quiet.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_resync_count <= '0;
            r_packet_count <= '0;
            r_drop_count   <= '0;
        end else begin
            if (w_resync_hit && (r_resync_count != 16'hFFFF)) begin
                r_resync_count <= r_resync_count + 16'd1;
            end
            if (r_start_packet && (r_packet_count != 16'hFFFF)) begin
                r_packet_count <= r_packet_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign o_resync_count = r_resync_count;
    assign o_packet_count = r_packet_count;
    assign o_drop_count   = r_drop_count;
`endif

    assign o_fifo_output_word  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_fifo_is_empty_sig = w_empty;
    assign o_fifo_is_full_sig  = w_full;
    assign o_fifo_level        = r_level;
    assign o_start_packet_sig  = r_start_packet;
    assign o_overflow_sig      = r_overflow;
    assign o_state             = r_state;

endmodule

// File: tb/tb_pc_rx_framer.sv
// tb_pc_rx_framer: directed checks of framing, packing order, FIFO boundaries and reset.
// Two instances share the stimulus: MSB-first and LSB-first packing, both with a 4-word FIFO.
module tb_pc_rx_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic        readCmd;

    logic [31:0] wordOut;
    logic        emptySig;
    logic        fullSig;
    logic [2:0]  level;
    logic        startPulse;
    logic        overflowSig;
    logic [1:0]  state;

    logic [31:0] lsbWordOut;
    logic        lsbEmptySig;
    logic        lsbFullSig;
    logic [2:0]  lsbLevel;
    logic        lsbStartPulse;
    logic        lsbOverflowSig;
    logic [1:0]  lsbState;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_rx_framer #(.WORD_BYTES(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_dut (
        .i_clock              (clock),
        .i_reset              (reset),
        .i_rx_byte            (rxByte),
        .i_rx_byte_valid      (rxValid),
        .i_read_next_word_cmd (readCmd),
        .o_fifo_output_word   (wordOut),
        .o_fifo_is_empty_sig  (emptySig),
        .o_fifo_is_full_sig   (fullSig),
        .o_fifo_level         (level),
        .o_start_packet_sig   (startPulse),
        .o_overflow_sig       (overflowSig),
        .o_state              (state)
    );

    pc_rx_framer #(.WORD_BYTES(4), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
        .i_clock              (clock),
        .i_reset              (reset),
        .i_rx_byte            (rxByte),
        .i_rx_byte_valid      (rxValid),
        .i_read_next_word_cmd (readCmd),
        .o_fifo_output_word   (lsbWordOut),
        .o_fifo_is_empty_sig  (lsbEmptySig),
        .o_fifo_is_full_sig   (lsbFullSig),
        .o_fifo_level         (lsbLevel),
        .o_start_packet_sig   (lsbStartPulse),
        .o_overflow_sig       (lsbOverflowSig),
        .o_state              (lsbState)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock edge; returns 1 time unit after it so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxByte  = b;
        rxValid = 1'b1;
        tick();
        rxValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[31:24]);
        applyStimulus(w[23:16]);
        applyStimulus(w[15:8]);
        applyStimulus(w[7:0]);
    endtask

    task automatic popOnce();
        readCmd = 1'b1;
        tick();
        readCmd = 1'b0;
    endtask

    initial begin
        logic [31:0] drainWords [4];
        drainWords[0] = 32'hA2B2C2D2;
        drainWords[1] = 32'hA3B3C3D3;
        drainWords[2] = 32'hA4B4C4D4;
        drainWords[3] = 32'hA5B5C5D5;

        reset   = 1'b1;
        rxByte  = 8'h00;
        rxValid = 1'b0;
        readCmd = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_state", state, 2'd0);
        checkOutput("rst_empty", emptySig, 1'b1);
        checkOutput("rst_full", fullSig, 1'b0);
        checkOutput("rst_level", level, 3'd0);
        checkOutput("rst_word", wordOut, 32'h0);
        checkOutput("rst_start", startPulse, 1'b0);
        checkOutput("rst_ovf", overflowSig, 1'b0);

        $display("[TB] resync, magic, first word");
        sendWord(32'h416FDC1E);
        checkOutput("pre_state", state, 2'd1);
        applyStimulus(8'hD7);
        applyStimulus(8'h8C);
        applyStimulus(8'h1B);
        checkOutput("start_early", startPulse, 1'b0);
        applyStimulus(8'h74);
        checkOutput("start_pulse", startPulse, 1'b1);
        checkOutput("data_state", state, 2'd2);
        tick();
        checkOutput("start_once", startPulse, 1'b0);

        sendWord(32'h01020304);
        checkOutput("empty_latency", emptySig, 1'b1);
        readCmd = 1'b1;
        tick();
        readCmd = 1'b0;
        checkOutput("w1_empty", emptySig, 1'b0);
        checkOutput("w1_level", level, 3'd1);
        checkOutput("w1_word", wordOut, 32'h01020304);
        checkOutput("w1_lsb_word", lsbWordOut, 32'h04030201);
        popOnce();
        checkOutput("pop_empty", emptySig, 1'b1);
        checkOutput("pop_word", wordOut, 32'h0);
        checkOutput("pop_level", level, 3'd0);
        popOnce();
        checkOutput("pop_on_empty_level", level, 3'd0);
        checkOutput("pop_on_empty_empty", emptySig, 1'b1);

        $display("[TB] resync inside payload");
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        sendWord(32'h416FDC1E);
        checkOutput("rs_state", state, 2'd1);
        checkOutput("rs_level", level, 3'd1);
        checkOutput("rs_word", wordOut, 32'hAABB416F);
        checkOutput("rs_lsb_word", lsbWordOut, 32'h6F41BBAA);
        popOnce();
        sendWord(32'hD78C1B74);
        checkOutput("rs_start", startPulse, 1'b1);
        sendWord(32'h416FDC1E);
        tick();
        checkOutput("rs_aligned_state", state, 2'd1);
        checkOutput("rs_aligned_empty", emptySig, 1'b1);
        sendWord(32'hD78C1B74);
        sendWord(32'h11223344);
        tick();
        checkOutput("rs_after_level", level, 3'd1);
        checkOutput("rs_after_word", wordOut, 32'h11223344);
        checkOutput("rs_after_lsb", lsbWordOut, 32'h44332211);
        popOnce();

        $display("[TB] fill, full pop+write, overflow");
        sendWord(32'hA1B1C1D1);
        sendWord(32'hA2B2C2D2);
        sendWord(32'hA3B3C3D3);
        sendWord(32'hA4B4C4D4);
        tick();
        checkOutput("full_flag", fullSig, 1'b1);
        checkOutput("full_level", level, 3'd4);
        checkOutput("full_ovf", overflowSig, 1'b0);
        checkOutput("full_head", wordOut, 32'hA1B1C1D1);
        sendWord(32'hA5B5C5D5);
        readCmd = 1'b1;
        tick();
        readCmd = 1'b0;
        checkOutput("pw_level", level, 3'd4);
        checkOutput("pw_head", wordOut, 32'hA2B2C2D2);
        checkOutput("pw_ovf", overflowSig, 1'b0);
        sendWord(32'hA6B6C6D6);
        tick();
        checkOutput("ovf_set", overflowSig, 1'b1);
        checkOutput("ovf_level", level, 3'd4);
        checkOutput("ovf_head", wordOut, 32'hA2B2C2D2);
        checkOutput("ovf_lsb_head", lsbWordOut, 32'hD2C2B2A2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_%0d", i), wordOut, {32'h0, drainWords[i]});
            popOnce();
        end
        checkOutput("drain_empty", emptySig, 1'b1);
        checkOutput("drain_ovf_sticky", overflowSig, 1'b1);

        $display("[TB] reset mid-word");
        sendWord(32'h55667788);
        tick();
        checkOutput("pre_rst_level", level, 3'd1);
        applyStimulus(8'h99);
        rxByte  = 8'h9A;
        rxValid = 1'b1;
        reset   = 1'b1;
        tick();
        rxValid = 1'b0;
        reset   = 1'b0;
        checkOutput("mid_rst_state", state, 2'd0);
        checkOutput("mid_rst_empty", emptySig, 1'b1);
        checkOutput("mid_rst_level", level, 3'd0);
        checkOutput("mid_rst_ovf", overflowSig, 1'b0);
        checkOutput("mid_rst_word", wordOut, 32'h0);
        checkOutput("mid_rst_lsb_empty", lsbEmptySig, 1'b1);
        sendWord(32'h01020304);
        sendWord(32'h05060708);
        tick();
        tick();
        checkOutput("ignored_empty", emptySig, 1'b1);
        checkOutput("ignored_state", state, 2'd0);
        checkOutput("ignored_lsb_state", lsbState, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
